// File: rtl/crc_mem_reader.sv
// Read-side CRC-8 checker: streams a block of bytes out of a synchronous-read memory,
// folds them into a CRC-8 and compares the result with the stored CRC byte that follows the block.
module crc_mem_reader #(
    parameter int          DATA_W = 8,
    parameter int          ADDR_W = 4,
    parameter logic [7:0]  POLY   = 8'h07,
    parameter logic [7:0]  INIT   = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              done,
    output logic              crc_ok,
    output logic [7:0]        crc_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] len_p0;
    logic [ADDR_W-1:0] idx_p0;
    logic              vld_p1;
    logic [7:0]        crc_p1;
    logic [7:0]        rd_byte;

    // MSB-first, non-reflected CRC-8 update of one whole byte (8 unrolled steps).
    function automatic logic [7:0] crc8_fold(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in;
        for (int k = 7; k >= 0; k--) begin
            if (c[7] ^ data[k]) begin
                c = {c[6:0], 1'b0} ^ POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    // The CRC datapath is byte-wide; DATA_W is expected to be 8.
    assign rd_byte = mem_rd_data[7:0];

    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                mem_rd_en = 1'b1;
                busy      = 1'b1;
                if (idx_p0 == len_p0) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0 issues addresses; stage p1 consumes the data returned one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_addr <= '0;
            len_p0   <= '0;
            idx_p0   <= '0;
            vld_p1   <= 1'b0;
            crc_p1   <= INIT;
            crc_out  <= 8'h00;
            crc_ok   <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= mem_rd_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr <= base_addr;
                        len_p0   <= length;
                        idx_p0   <= '0;
                        crc_p1   <= INIT;
                        crc_ok   <= 1'b0;
                    end
                end
                FETCH: begin
                    idx_p0 <= idx_p0 + ADDR_W'(1);
                    // Address stays on the CRC byte after the final issue.
                    if (idx_p0 != len_p0) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                    // Every return landing while still fetching is a data byte.
                    if (vld_p1) begin
                        crc_p1 <= crc8_fold(crc_p1, rd_byte);
                    end
                end
                DRAIN: begin
                    crc_out <= crc_p1;
                    crc_ok  <= (rd_byte == crc_p1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_mem_reader.sv
// Directed and randomized checks of crc_mem_reader against a long-division CRC reference
// and a cycle-accurate expectation of the read/busy/done timeline.
module tb_crc_mem_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] base_addr;
    logic [3:0] length;
    logic       mem_rd_en;
    logic [3:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       busy;
    logic       done;
    logic       crc_ok;
    logic [7:0] crc_out;

    logic [7:0] mem [16];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    crc_mem_reader #(
        .DATA_W(8), .ADDR_W(4), .POLY(8'h07), .INIT(8'h00)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .busy(busy), .done(done), .crc_ok(crc_ok), .crc_out(crc_out)
    );

    // Synchronous-read memory model.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC as remainder of M(x)*x^8 divided by x^8+x^2+x+1 (valid for INIT=0).
    function automatic logic [7:0] ref_crc(input logic [3:0] b, input logic [3:0] l);
        int r;
        logic [7:0] d;
        r = 0;
        for (int i = 0; i < int'(l); i++) begin
            d = mem[(int'(b) + i) % 16];
            for (int bi = 7; bi >= 0; bi--) begin
                r = (r << 1) | int'(d[bi]);
                if ((r & 'h100) != 0) r = r ^ 'h107;
            end
        end
        for (int z = 0; z < 8; z++) begin
            r = r << 1;
            if ((r & 'h100) != 0) r = r ^ 'h107;
        end
        return 8'(r);
    endfunction

    task automatic set_golden();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        for (int i = 0; i < 9; i++) mem[i] = 8'(8'h31 + i);
        mem[9] = 8'hF4;
    endtask

    // Runs one check and verifies the full cycle-by-cycle timeline; poke adds ignored start pulses.
    task automatic run_check(input logic [3:0] b, input logic [3:0] l, input bit poke, input string tag);
        logic [7:0] exp_crc;
        logic       exp_ok;
        logic [3:0] ea;
        exp_crc = ref_crc(b, l);
        exp_ok  = (mem[(int'(b) + int'(l)) % 16] == exp_crc);
        @(negedge clk);
        check({tag, "_idle_busy"}, busy, 1'b0);
        start = 1'b1; base_addr = b; length = l;
        for (int k = 1; k <= int'(l) + 3; k++) begin
            @(negedge clk);
            start = poke && (k == 2 || k == int'(l) + 3);
            base_addr = 4'($urandom_range(0, 15));
            length    = 4'($urandom_range(0, 15));
            check({tag, "_rd_en"}, mem_rd_en, (k <= int'(l) + 1));
            if (k <= int'(l) + 1) begin
                ea = b + 4'(k - 1);
                check({tag, "_addr"}, mem_addr, ea);
            end
            check({tag, "_busy"}, busy, (k <= int'(l) + 2));
            check({tag, "_done"}, done, (k == int'(l) + 3));
        end
        check({tag, "_crc_out"}, crc_out, exp_crc);
        check({tag, "_crc_ok"}, crc_ok, exp_ok);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_after_done"}, done, 1'b0);
        @(negedge clk);
        check({tag, "_no_requeue"}, busy, 1'b0);
        check({tag, "_hold_crc"}, crc_out, exp_crc);
        check({tag, "_hold_ok"}, crc_ok, exp_ok);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int dcount;
        bit seen;
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_addr", mem_addr, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ok", crc_ok, 1'b0);
        check("rst_crc", crc_out, 8'h00);
        rst = 1'b0;

        // Golden "123456789" vector.
        set_golden();
        run_check(4'd0, 4'd9, 1'b0, "golden");
        check("golden_f4", crc_out, 8'hF4);
        check("golden_ok1", crc_ok, 1'b1);

        // Corrupted byte.
        mem[4] = 8'h36;
        run_check(4'd0, 4'd9, 1'b0, "corrupt");
        check("corrupt_ok0", crc_ok, 1'b0);
        check("corrupt_ne", (crc_out != 8'hF4), 1'b1);

        // Single byte.
        mem[3] = 8'h01; mem[4] = 8'h07;
        run_check(4'd3, 4'd1, 1'b0, "single");
        check("single_crc07", crc_out, 8'h07);
        check("single_ok1", crc_ok, 1'b1);

        // Empty block and wrap-around.
        mem[5] = 8'h00;
        run_check(4'd5, 4'd0, 1'b0, "empty");
        check("empty_crc", crc_out, 8'h00);
        check("empty_ok1", crc_ok, 1'b1);
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        run_check(4'd14, 4'd3, 1'b0, "wrap");

        // Reset during FETCH of the golden run.
        set_golden();
        @(negedge clk);
        start = 1'b1; base_addr = 4'd0; length = 4'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_rd_en", mem_rd_en, 1'b0);
        check("midrst_addr", mem_addr, 4'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_ok", crc_ok, 1'b0);
        check("midrst_crc", crc_out, 8'h00);
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midrst_no_done", dcount, 0);

        // Restart with extra start pulses that must be ignored.
        run_check(4'd0, 4'd9, 1'b1, "restart_poke");
        check("restart_ok1", crc_ok, 1'b1);

        // Start held high: accepted once, then again right after DONE.
        mem[3] = 8'h01; mem[4] = 8'h07;
        @(negedge clk);
        start = 1'b1; base_addr = 4'd3; length = 4'd1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) check("hold_busy_k1", busy, 1'b1);
            if (k == 4) check("hold_done_k4", done, 1'b1);
            if (k == 5) check("hold_idle_k5", busy, 1'b0);
            if (k == 6) check("hold_rebusy_k6", busy, 1'b1);
        end
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("hold_second_done", seen, 1'b1);
        check("hold_second_ok", crc_ok, 1'b1);

        // Randomized blocks, half of them with a correct stored CRC.
        for (int it = 0; it < 10; it++) begin
            logic [3:0] rb, rl;
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            rb = 4'($urandom_range(0, 15));
            rl = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) mem[(int'(rb) + int'(rl)) % 16] = ref_crc(rb, rl);
            run_check(rb, rl, it[0], "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc_mem_reader.md
Name: crc_mem_reader

Overview:
- Read-side checker for the CRC-protected memory path.
- On a start pulse, it streams a block of data bytes out of a synchronous-read memory and computes CRC-8 over them.
- It then fetches the stored CRC byte that follows the block and reports pass/fail.
- It is the counterpart of the write path, which stores data followed by its CRC byte.

Parameters:
- DATA_W, 8, memory word width; the CRC datapath is fixed at 8 bits, so only 8 is legal.
- ADDR_W, 4, memory address width; also the width of length.
- POLY, 8'h07, CRC-8 generator polynomial, with the x^8 term implicit.
- INIT, 8'h00, CRC register initial value.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a check; sampled only in IDLE.
- base_addr  in  ADDR_W  first data address; captured when start is accepted.
- length  in  ADDR_W  number of data bytes (0..2^ADDR_W-1); captured when start is accepted.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  DATA_W  read data; valid the cycle after mem_rd_en.
- busy  out  1  check in progress.
- done  out  1  one-cycle completion pulse.
- crc_ok  out  1  computed CRC equals the stored CRC byte.
- crc_out  out  8  CRC computed over the data bytes.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values:
  - mem_rd_en=0, mem_addr=0, busy=0, done=0, crc_ok=0, crc_out=0.
  - FSM=IDLE, CRC register=INIT.
- CRC algorithm: CRC-8, MSB-first, non-reflected, no final XOR.
  - Each byte is folded in one cycle as 8 unrolled shift/XOR steps: crc = (crc<<1) ^ (POLY if (crc[7]^bit)).
  - Check value for ASCII "123456789" is 0xF4.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - If start=1, capture base_addr and length, clear crc_ok, load CRC register with INIT, go to FETCH.
  - Let T be this acceptance cycle.
- FETCH:
  - busy=1 and mem_rd_en=1.
  - mem_addr = base+i for i=0..length, one address per cycle: length+1 reads in cycles T+1..T+1+length.
  - The final read (i=length) is the stored CRC byte.
  - After the final issue, go to DRAIN.
- Data capture:
  - mem_rd_data returned for address i is sampled on the edge ending the cycle after issue.
  - Returns for i<length are folded into the CRC register.
  - The return for i=length is compared against the final CRC value.
- DRAIN:
  - mem_rd_en=0, busy=1.
  - Captures the stored CRC byte (the cycle-T+2+length return).
  - Loads crc_out with the computed CRC and crc_ok with (computed == stored).
  - Goes to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, in cycle T+3+length; then go to IDLE.
- Latency: done rises length+3 cycles after start is sampled.
- Output hold: crc_out and crc_ok hold their values until the next accepted start; crc_ok clears on acceptance.
- Address arithmetic: modulo 2^ADDR_W. base+i wraps past the top of memory; no error is flagged.
- length=0: a single read at base. crc_out=INIT and crc_ok=(mem[base]==INIT). done occurs 3 cycles after start.
- start while busy or in DONE: ignored, with no queuing.
- start held high in IDLE: accepted once. A new check begins the cycle after DONE if start is still high.
- Reset mid-operation: in any state, rst=1 forces the reset values on the next edge. Any pending read data is discarded, and no done pulse is produced.
- mem_addr: holds its last value when mem_rd_en=0; the memory must ignore it.

Test Plan:
- Golden vector:
  - Stimulus: mem[0..8]=0x31..0x39, mem[9]=0xF4; start with base=0, length=9 at cycle T.
  - Required response: reads at addresses 0..9 in cycles T+1..T+10; done in cycle T+12 only; crc_out=0xF4, crc_ok=1; busy high T+1..T+11.
- Corruption:
  - Stimulus: same block but mem[4]=0x36.
  - Required response: done at T+12; crc_ok=0; crc_out≠0xF4.
- Single byte:
  - Stimulus: mem[3]=0x01, mem[4]=0x07; base=3, length=1.
  - Required response: crc_out=0x07, crc_ok=1, done 4 cycles after start.
- Empty block and wrap-around:
  - Stimulus A: length=0 with mem[5]=0x00, base=5.
  - Required response A: crc_ok=1, crc_out=0x00, done after 3 cycles.
  - Stimulus B: base=14, length=3 (ADDR_W=4).
  - Required response B: mem_addr sequence 14,15,0,1.
- Reset and start filtering:
  - Stimulus: assert rst during FETCH of the golden run.
  - Required response: next cycle all outputs are 0 and no done pulse follows.
  - Stimulus: pulse start again mid-run after restarting.
  - Required response: the second pulse is ignored; exactly one done pulse with crc_ok=1.
